// File: rtl/dwt_level_scheduler.sv
// Issue scheduler for the cascaded deep levels of the sym4 DWT. It shares one
// MAC pipeline across all levels and routes each tagged result to the next level.
module dwt_level_scheduler #(
    parameter int NUM_LEVELS  = 3,
    parameter int LEVEL_W     = 2,
    parameter int WARMUP      = 7,
    parameter int MAC_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  din_valid,
    output logic [NUM_LEVELS-1:0] hist_we,
    output logic                  mac_start,
    output logic [LEVEL_W-1:0]    mac_level,
    output logic                  res_valid,
    output logic [LEVEL_W-1:0]    res_level,
    output logic [NUM_LEVELS-1:0] overflow,
    output logic                  busy
);

    localparam int CNT_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

    logic [CNT_W-1:0]      cnt_r [NUM_LEVELS];
    logic [NUM_LEVELS-1:0] phase_r;
    logic [NUM_LEVELS-1:0] req_r;
    logic [NUM_LEVELS-1:0] overflow_r;
    logic [NUM_LEVELS-1:0] rq_ev_s;
    logic [NUM_LEVELS-1:0] grant_oh_s;
    logic                  grant_valid_s;
    logic [LEVEL_W-1:0]    grant_level_s;
    logic                  mac_start_r;
    logic [LEVEL_W-1:0]    mac_level_r;
    logic [MAC_LATENCY-1:0] tag_valid_r;
    logic [LEVEL_W-1:0]    tag_level_r [MAC_LATENCY];

    // Highest set index; deeper levels have fewer samples and must never starve.
    function automatic logic [LEVEL_W-1:0] top_level(input logic [NUM_LEVELS-1:0] v);
        logic [LEVEL_W-1:0] idx;
        idx = '0;
        for (int l = 0; l < NUM_LEVELS; l++) begin
            if (v[l]) begin
                idx = LEVEL_W'(l);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Sample events: raw input for level 0, routed results for deeper levels.
    always_comb begin
        hist_we    = '0;
        hist_we[0] = din_valid;
        for (int l = 0; l < NUM_LEVELS - 1; l++) begin
            if (tag_valid_r[MAC_LATENCY-1] && (tag_level_r[MAC_LATENCY-1] == LEVEL_W'(l))) begin
                hist_we[l+1] = 1'b1;
            end else begin
                hist_we[l+1] = 1'b0;
            end
        end
    end

    // Request events and fixed-priority grant.
    always_comb begin
        rq_ev_s       = '0;
        grant_oh_s    = '0;
        grant_valid_s = enable && (|req_r);
        grant_level_s = top_level(req_r);
        for (int l = 0; l < NUM_LEVELS; l++) begin
            rq_ev_s[l]    = hist_we[l] && (cnt_r[l] == CNT_W'(WARMUP)) && !phase_r[l];
            grant_oh_s[l] = grant_valid_s && (grant_level_s == LEVEL_W'(l));
        end
    end

    // Per-level warm-up counter, decimation phase, request and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int l = 0; l < NUM_LEVELS; l++) begin
                cnt_r[l] <= '0;
            end
            phase_r    <= '0;
            req_r      <= '0;
            overflow_r <= '0;
        end else begin
            for (int l = 0; l < NUM_LEVELS; l++) begin
                if (hist_we[l]) begin
                    if (cnt_r[l] != CNT_W'(WARMUP)) begin
                        cnt_r[l] <= cnt_r[l] + CNT_W'(1);
                    end else begin
                        phase_r[l] <= ~phase_r[l];
                    end
                end
                // A new request on the grant edge wins over the clear.
                if (rq_ev_s[l]) begin
                    req_r[l] <= 1'b1;
                end else if (grant_oh_s[l]) begin
                    req_r[l] <= 1'b0;
                end
                if (rq_ev_s[l] && req_r[l] && !grant_oh_s[l]) begin
                    overflow_r[l] <= 1'b1;
                end
            end
        end
    end

    // Issue register and level tag pipeline matching the MAC latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mac_start_r <= 1'b0;
            mac_level_r <= '0;
            tag_valid_r <= '0;
            for (int i = 0; i < MAC_LATENCY; i++) begin
                tag_level_r[i] <= '0;
            end
        end else begin
            mac_start_r    <= grant_valid_s;
            mac_level_r    <= grant_valid_s ? grant_level_s : '0;
            tag_valid_r[0] <= mac_start_r;
            tag_level_r[0] <= mac_level_r;
            for (int i = 1; i < MAC_LATENCY; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_level_r[i] <= tag_level_r[i-1];
            end
        end
    end

    assign mac_start = mac_start_r;
    assign mac_level = mac_level_r;
    assign res_valid = tag_valid_r[MAC_LATENCY-1];
    assign res_level = tag_level_r[MAC_LATENCY-1];
    assign overflow  = overflow_r;
    assign busy      = (|req_r) || mac_start_r || (|tag_valid_r);

endmodule

// File: tb/tb_dwt_level_scheduler.sv
// Self-checking bench for dwt_level_scheduler: a cycle model predicts issues,
// and a result scoreboard queue holds each expected tagged result with its due cycle.
module tb_dwt_level_scheduler;

    localparam int NL = 3;
    localparam int LW = 2;
    localparam int WU = 7;
    localparam int ML = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          din_valid;
    logic [NL-1:0] hist_we;
    logic          mac_start;
    logic [LW-1:0] mac_level;
    logic          res_valid;
    logic [LW-1:0] res_level;
    logic [NL-1:0] overflow;
    logic          busy;

    always #5 clk = ~clk;

    dwt_level_scheduler #(
        .NUM_LEVELS(NL), .LEVEL_W(LW), .WARMUP(WU), .MAC_LATENCY(ML)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din_valid(din_valid),
        .hist_we(hist_we), .mac_start(mac_start), .mac_level(mac_level),
        .res_valid(res_valid), .res_level(res_level), .overflow(overflow), .busy(busy)
    );

    typedef struct {
        int level;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   mk[NL];
    bit   mreq[NL];
    bit   movf[NL];
    bit   mstart;
    int   mlevel;

    int first_start, first_lvl, first_res, second_start, nstarts;
    int l2_seen, issues, got, res_seen;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit m_res_v();
        return (exp_q.size() > 0) && (exp_q[0].due == cyc);
    endfunction

    function automatic int m_res_l();
        return m_res_v() ? exp_q[0].level : 0;
    endfunction

    // One clock: check hist_we before the edge, advance the model, check registered outputs after.
    task automatic step();
        logic [NL-1:0] ehw;
        logic [NL-1:0] eovf;
        bit rq;
        bit gv;
        int g;
        bit any_req;
        @(negedge clk);
        ehw[0] = din_valid;
        for (int l = 1; l < NL; l++) ehw[l] = m_res_v() && (m_res_l() == l - 1);
        chk("hist_we", 32'(hist_we), 32'(ehw));
        @(posedge clk);
        if (!rst_n) begin
            for (int l = 0; l < NL; l++) begin
                mk[l] = 0; mreq[l] = 1'b0; movf[l] = 1'b0;
            end
            exp_q.delete();
            mstart = 1'b0;
            mlevel = 0;
        end else begin
            gv = 1'b0;
            g  = 0;
            for (int l = 0; l < NL; l++) begin
                if (enable && mreq[l]) begin gv = 1'b1; g = l; end
            end
            for (int l = 0; l < NL; l++) begin
                rq = ehw[l] && (mk[l] >= WU) && (((mk[l] - WU) % 2) == 0);
                if (ehw[l]) mk[l]++;
                if (rq && mreq[l] && !(gv && g == l)) movf[l] = 1'b1;
                if (rq) mreq[l] = 1'b1;
                else if (gv && g == l) mreq[l] = 1'b0;
            end
            if (m_res_v()) void'(exp_q.pop_front());
            mstart = gv;
            mlevel = gv ? g : 0;
            if (gv) exp_q.push_back('{level: g, due: cyc + 1 + ML});
        end
        cyc++;
        #1;
        any_req = 1'b0;
        for (int l = 0; l < NL; l++) begin
            eovf[l] = movf[l];
            any_req = any_req | mreq[l];
        end
        chk("mac_start", 32'(mac_start), 32'(mstart));
        chk("mac_level", 32'(mac_level), 32'(mlevel));
        chk("res_valid", 32'(res_valid), 32'(m_res_v()));
        chk("res_level", 32'(res_level), 32'(m_res_l()));
        chk("overflow", 32'(overflow), 32'(eovf));
        chk("busy", 32'(busy), 32'(any_req || (exp_q.size() > 0)));
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        din_valid = 1'b1;
        for (int l = 0; l < NL; l++) begin
            mk[l] = 0; mreq[l] = 1'b0; movf[l] = 1'b0;
        end
        mstart = 1'b0;
        mlevel = 0;
        repeat (2) @(posedge clk);

        // Reset held with din_valid high, then quiet release.
        repeat (3) step();
        rst_n     = 1'b1;
        din_valid = 1'b0;
        repeat (3) begin
            step();
            chk("no_start_after_rst", 32'(mac_start), 32'd0);
        end

        // Warm-up and 2:1 down-sampling with samples on even cycles.
        first_start = -1; first_lvl = -1; first_res = -1; second_start = -1; nstarts = 0;
        for (int t = 0; t < 24; t++) begin
            din_valid = ((t % 2) == 0);
            step();
            if (mac_start) begin
                nstarts++;
                if (nstarts == 1) begin first_start = t + 1; first_lvl = mac_level; end
                if (nstarts == 2) second_start = t + 1;
            end
            if (res_valid && first_res < 0) first_res = t + 1;
            if (t + 1 == 19) chk("hw1_at_19", 32'(hist_we[1]), 32'd1);
        end
        chk("first_start_cyc", 32'(first_start), 32'd16);
        chk("first_start_lvl", 32'(first_lvl), 32'd0);
        chk("first_res_cyc", 32'(first_res), 32'd19);
        chk("second_start_cyc", 32'(second_start), 32'd20);

        // Cascade at full input rate.
        din_valid = 1'b0;
        do_reset(2);
        din_valid = 1'b1;
        l2_seen = 0;
        for (int t = 0; t < 200; t++) begin
            step();
            if (res_valid && res_level == 2'd2) l2_seen++;
        end
        din_valid = 1'b0;
        repeat (40) step();
        chk("cascade_l2_results", 32'(l2_seen > 0), 32'd1);
        chk("cascade_no_overflow", 32'(overflow), 32'd0);

        // Random input and enable: contention and overflow checked by the model.
        do_reset(2);
        for (int t = 0; t < 600; t++) begin
            din_valid = 1'($urandom_range(0, 1));
            enable    = ($urandom_range(0, 4) != 0);
            step();
        end
        enable    = 1'b1;
        din_valid = 1'b0;
        repeat (20) step();

        // Overflow: enable low across samples k = 0..9.
        do_reset(2);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            din_valid = 1'b1; step();
            din_valid = 1'b0; step();
        end
        chk("ovf_flag", 32'(overflow[0]), 32'd1);
        chk("ovf_req_pending", 32'(busy), 32'd1);
        enable = 1'b1;
        issues = 0;
        repeat (10) begin
            step();
            if (mac_start && mac_level == 2'd0) issues++;
        end
        chk("ovf_one_issue", 32'(issues), 32'd1);
        repeat (5) step();
        chk("ovf_sticky", 32'(overflow[0]), 32'd1);

        // Mid-flight reset one cycle after an issue.
        do_reset(2);
        chk("ovf_cleared_by_rst", 32'(overflow), 32'd0);
        din_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 60 && got == 0; i++) begin
            step();
            if (mac_start) got = 1;
        end
        chk("mf_start_seen", 32'(got), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        chk("mf_busy_after_rst", 32'(busy), 32'd0);
        rst_n     = 1'b1;
        din_valid = 1'b0;
        res_seen  = 0;
        repeat (8) begin
            step();
            if (res_valid) res_seen++;
        end
        chk("mf_no_result", 32'(res_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
